// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: button/soft-request inputs and staged reset outputs of the reset sequencer
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 3
);
    logic                   io_button;
    logic                   io_soft_reset;
    logic [NUM_DOMAINS-1:0] io_resets;
    logic                   io_ready;
    logic [1:0]             io_cause;
    modport master (output io_button, io_soft_reset, input io_resets, io_ready, io_cause);
    modport slave  (input io_button, io_soft_reset, output io_resets, io_ready, io_cause);
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: debounced button / soft reset request, minimum hold, then staged per-domain release
module reset_sequencer #(
    parameter int SYNC_STAGES       = 2,
    parameter int BUTTON_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int HOLD_CYCLES       = 64,
    parameter int NUM_DOMAINS       = 3,
    parameter int RELEASE_GAP       = 8
) (
    input logic clock,
    input logic reset,
    reset_sequencer_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int GW = $clog2(RELEASE_GAP) + 1;
    localparam int IW = $clog2(NUM_DOMAINS) + 1;

    typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   pressed, btn_db, btn_prev, btn_rise, req;
    logic [DW-1:0]          db_cnt;
    logic [HW-1:0]          hold_cnt, hold_next;
    logic [GW-1:0]          gap_cnt, gap_next;
    logic [IW-1:0]          idx, idx_next;
    logic [NUM_DOMAINS-1:0] resets_q, resets_next;
    logic                   ready_q, ready_next;
    logic [1:0]             cause_q, cause_next;

    assign pressed  = (BUTTON_ACTIVE_LOW != 0) ? ~bus.io_button : bus.io_button;
    assign btn_rise = btn_db & ~btn_prev;
    assign req      = btn_rise | bus.io_soft_reset;

    assign bus.io_resets = resets_q;
    assign bus.io_ready  = ready_q;
    assign bus.io_cause  = cause_q;

    // Synchronise the pin and only accept a new level after it has been stable long enough
    always_ff @(posedge clock) begin
        if (reset) begin
            sync     <= '0;
            btn_db   <= 1'b0;
            btn_prev <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], pressed};
            btn_prev <= btn_db;
            if (sync[SYNC_STAGES-1] == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= sync[SYNC_STAGES-1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Sequencer state, counters and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ASSERT;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            resets_q <= '1;
            ready_q  <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            gap_cnt  <= gap_next;
            idx      <= idx_next;
            resets_q <= resets_next;
            ready_q  <= ready_next;
            cause_q  <= cause_next;
        end
    end

    // Next-state and output decode; a request outside ASSERT re-asserts every domain at once
    always_comb begin
        state_next  = state;
        hold_next   = hold_cnt;
        gap_next    = gap_cnt;
        idx_next    = idx;
        resets_next = resets_q;
        ready_next  = ready_q;
        cause_next  = btn_rise ? 2'd1 : bus.io_soft_reset ? 2'd2 : cause_q;
        case (state)
            ASSERT: begin
                resets_next = '1;
                ready_next  = 1'b0;
                if (btn_db || bus.io_soft_reset) begin
                    hold_next = '0;
                end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    state_next = RELEASE;
                    idx_next   = '0;
                    gap_next   = '0;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (req) begin
                    state_next  = ASSERT;
                    hold_next   = '0;
                    resets_next = '1;
                    ready_next  = 1'b0;
                end else begin
                    if (gap_cnt == '0) begin
                        for (int k = 0; k < NUM_DOMAINS; k++)
                            if (idx == IW'(k)) resets_next[k] = 1'b0;
                        if (idx == IW'(NUM_DOMAINS - 1)) state_next = RUN;
                    end
                    gap_next = (gap_cnt == GW'(RELEASE_GAP - 1)) ? '0 : gap_cnt + 1'b1;
                    if (gap_cnt == GW'(RELEASE_GAP - 1) && idx != IW'(NUM_DOMAINS - 1))
                        idx_next = idx + 1'b1;
                end
            end
            RUN: begin
                resets_next = '0;
                ready_next  = 1'b1;
                if (req) begin
                    state_next  = ASSERT;
                    hold_next   = '0;
                    resets_next = '1;
                    ready_next  = 1'b0;
                end
            end
            default: state_next = ASSERT;
        endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed timing checks of the reset sequencer, default and minimal parameter sets
module tb_reset_sequencer;
    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    reset_sequencer_if #(.NUM_DOMAINS(3)) sif ();
    reset_sequencer_if #(.NUM_DOMAINS(1)) sif1 ();

    reset_sequencer dut (.clock(clock), .reset(reset), .bus(sif.slave));

    reset_sequencer #(.NUM_DOMAINS(1), .RELEASE_GAP(1), .HOLD_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .bus(sif1.slave)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset              = 1'b1;
        sif.io_button      = 1'b1;
        sif.io_soft_reset  = 1'b0;
        sif1.io_button     = 1'b1;
        sif1.io_soft_reset = 1'b0;
        step(3);
        reset = 1'b0;
        chk("rst_resets", sif.io_resets, 8'h7);
        chk("rst_ready", sif.io_ready, 8'h0);
        chk("rst_cause", sif.io_cause, 8'h0);
        chk("min_rst_resets", sif1.io_resets, 8'h1);
        chk("min_rst_ready", sif1.io_ready, 8'h0);
        step(1);
        chk("min_c1_resets", sif1.io_resets, 8'h1);
        step(1);
        chk("min_c2_resets", sif1.io_resets, 8'h0);
        chk("min_c2_ready", sif1.io_ready, 8'h0);
        step(1);
        chk("min_c3_ready", sif1.io_ready, 8'h1);
        step(61);
        chk("por_c64", sif.io_resets, 8'h7);
        step(1);
        chk("por_c65", sif.io_resets, 8'h6);
        step(7);
        chk("por_c72", sif.io_resets, 8'h6);
        step(1);
        chk("por_c73", sif.io_resets, 8'h4);
        step(8);
        chk("por_c81", sif.io_resets, 8'h0);
        chk("por_c81_ready", sif.io_ready, 8'h0);
        step(1);
        chk("por_c82_ready", sif.io_ready, 8'h1);
        chk("por_cause", sif.io_cause, 8'h0);

        sif.io_button = 1'b0;
        step(10);
        sif.io_button = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            chk("glitch", {sif.io_resets, sif.io_ready}, 8'h1);
        end

        sif.io_button = 1'b0;
        step(18);
        chk("btn_p18", sif.io_resets, 8'h0);
        step(1);
        chk("btn_p19", sif.io_resets, 8'h7);
        chk("btn_p19_ready", sif.io_ready, 8'h0);
        chk("btn_cause", sif.io_cause, 8'h1);
        step(21);
        sif.io_button = 1'b1;
        step(82);
        chk("btn_p122", sif.io_resets, 8'h7);
        step(1);
        chk("btn_p123", sif.io_resets, 8'h6);
        step(8);
        chk("btn_p131", sif.io_resets, 8'h4);
        step(8);
        chk("btn_p139", sif.io_resets, 8'h0);
        chk("btn_p139_ready", sif.io_ready, 8'h0);
        step(1);
        chk("btn_p140_ready", sif.io_ready, 8'h1);
        chk("btn_p140_cause", sif.io_cause, 8'h1);

        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk("rst2_cause", sif.io_cause, 8'h0);
        step(65);
        chk("soft_c65", sif.io_resets, 8'h6);
        step(1);
        chk("soft_c66", sif.io_resets, 8'h6);
        sif.io_soft_reset = 1'b1;
        step(1);
        sif.io_soft_reset = 1'b0;
        chk("soft_c67", sif.io_resets, 8'h7);
        chk("soft_c67_ready", sif.io_ready, 8'h0);
        chk("soft_cause", sif.io_cause, 8'h2);
        step(64);
        chk("soft_c131", sif.io_resets, 8'h7);
        step(1);
        chk("soft_c132", sif.io_resets, 8'h6);
        step(16);
        chk("soft_c148", sif.io_resets, 8'h0);
        chk("soft_c148_ready", sif.io_ready, 8'h0);
        step(1);
        chk("soft_c149_ready", sif.io_ready, 8'h1);
        chk("soft_c149_cause", sif.io_cause, 8'h2);

        sif.io_button = 1'b0;
        step(18);
        sif.io_soft_reset = 1'b1;
        step(1);
        sif.io_soft_reset = 1'b0;
        chk("both_p19", sif.io_resets, 8'h7);
        chk("both_cause", sif.io_cause, 8'h1);
        step(1);
        sif.io_button = 1'b1;
        step(40);
        chk("both_p60", sif.io_resets, 8'h7);
        step(42);
        chk("both_p102", sif.io_resets, 8'h7);
        step(1);
        chk("both_p103", sif.io_resets, 8'h6);
        step(16);
        chk("both_p119_ready", sif.io_ready, 8'h0);
        step(1);
        chk("both_p120_ready", sif.io_ready, 8'h1);
        chk("both_p120_cause", sif.io_cause, 8'h1);

        reset = 1'b1;
        step(1);
        chk("grst_run_resets", sif.io_resets, 8'h7);
        chk("grst_run_ready", sif.io_ready, 8'h0);
        chk("grst_run_cause", sif.io_cause, 8'h0);
        reset = 1'b0;
        step(66);
        chk("grst_mid_pre", sif.io_resets, 8'h6);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("grst_mid_resets", sif.io_resets, 8'h7);
        step(64);
        chk("grst_mid_c64", sif.io_resets, 8'h7);
        step(1);
        chk("grst_mid_c65", sif.io_resets, 8'h6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
